// File: rtl/cint_pkg.sv
// Shared definitions for the constant-multiplier/divider pair: state encoding,
// derived-width helpers and the (digit, carry) -> digit*C+carry table generator.
package cint_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WORKING = 2'd1,
      DONE    = 2'd2
   } cint_state_e;

   function automatic int unsigned cint_carry_width(input int unsigned c);
      return $clog2(c + 1);
   endfunction

   function automatic int unsigned cint_num_slice(input int unsigned width, input int unsigned radix);
      return (width + radix - 1) / radix;
   endfunction

   function automatic int unsigned cint_lut_entry(input int unsigned digit, input int unsigned carry,
                                                  input int unsigned c);
      return digit * c + carry;
   endfunction

endpackage

// File: rtl/cint_mul_lut.sv
// Combinational ROM: {carry, digit} -> {next carry, result digit} for a fixed
// multiplier C. Entries are elaboration-time constants.
module cint_mul_lut
   import cint_pkg::*;
#(
   parameter int unsigned VALUE_MULTIPLIER = 10,
   parameter int unsigned WIDTH_RADIX      = 4,
   parameter int unsigned WIDTH_CARRY      = cint_carry_width(VALUE_MULTIPLIER)
) (
   input  logic [WIDTH_CARRY+WIDTH_RADIX-1:0] addr_i,
   output logic [WIDTH_CARRY+WIDTH_RADIX-1:0] data_o
);

   localparam int unsigned WIDTH_ENTRY = WIDTH_CARRY + WIDTH_RADIX;
   localparam int unsigned DEPTH       = 2 ** WIDTH_ENTRY;

   logic [WIDTH_ENTRY-1:0] rom [DEPTH];

   // digit*C + carry never exceeds WIDTH_ENTRY bits because C < 2^WIDTH_CARRY
   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = WIDTH_ENTRY'(cint_lut_entry(i % (2 ** WIDTH_RADIX), i / (2 ** WIDTH_RADIX),
                                                  VALUE_MULTIPLIER));
   end

   assign data_o = rom[addr_i];

endmodule

// File: rtl/cint_multiplier.sv
// Sequential constant multiplier: value = quotient*C + remainder, one radix slice
// per cycle LSB first. Define CINT_MUL_OVERFLOW_EN to enable overflow_o.
module cint_multiplier
   import cint_pkg::*;
#(
   parameter int unsigned VALUE_MULTIPLIER = 10,
   parameter int unsigned WIDTH_INPUT      = 32,
   parameter int unsigned WIDTH_RADIX      = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   valid_i,
   input  logic [WIDTH_INPUT-1:0] quotient_i,
   input  logic [WIDTH_INPUT-1:0] remainder_i,
   output logic                   busy_o,
   output logic                   valid_o,
   output logic                   valid_next_o,
   output logic [WIDTH_INPUT-1:0] value_o,
   output logic                   overflow_o
);

   localparam int unsigned WIDTH_CARRY = cint_carry_width(VALUE_MULTIPLIER);
   localparam int unsigned NUM_SLICE   = cint_num_slice(WIDTH_INPUT, WIDTH_RADIX);
   localparam int unsigned WIDTH_RES   = NUM_SLICE * WIDTH_RADIX;
   localparam int unsigned WIDTH_IDX   = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;
   localparam logic [WIDTH_IDX-1:0] IDX_TOP = WIDTH_IDX'(NUM_SLICE - 1);

   cint_state_e            state_q, state_d;
   logic [WIDTH_RES-1:0]   quot_ext, quot_q, result_q, result_d;
   logic [WIDTH_CARRY-1:0] carry_q, carry_nxt;
   logic [WIDTH_IDX-1:0]   index_q, last_q, last_acc;
   logic [WIDTH_RADIX-1:0] digit, digit_res;
   logic [31:0]            base;
   logic                   accept, finish;
   logic                   unused_rem;

   assign unused_rem = ^remainder_i;
   assign quot_ext   = WIDTH_RES'(quotient_i);
   assign accept     = !flush_i && valid_i && (state_q != WORKING);
   assign finish     = (state_q == WORKING) && (index_q == last_q);
   assign base       = 32'(index_q) * WIDTH_RADIX;
   assign digit      = quot_q[base +: WIDTH_RADIX];

   cint_mul_lut #(
      .VALUE_MULTIPLIER(VALUE_MULTIPLIER),
      .WIDTH_RADIX     (WIDTH_RADIX),
      .WIDTH_CARRY     (WIDTH_CARRY)
   ) u_lut (
      .addr_i({carry_q, digit}),
      .data_o({carry_nxt, digit_res})
   );

   // Highest nonzero slice bounds the work; leading zero slices are skipped.
   always_comb begin
      last_acc = '0;
      for (int i = 0; i < NUM_SLICE; i++) begin
         if (quot_ext[i*WIDTH_RADIX +: WIDTH_RADIX] != '0) last_acc = WIDTH_IDX'(i);
      end
   end

   // Carry is parked in the next slice every cycle; the final one is the top digit.
   always_comb begin
      result_d = result_q;
      result_d[base +: WIDTH_RADIX] = digit_res;
      if (index_q != IDX_TOP) result_d[base + WIDTH_RADIX +: WIDTH_RADIX] = WIDTH_RADIX'(carry_nxt);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (valid_i) state_d = WORKING;
         WORKING: if (index_q == last_q) state_d = DONE;
         DONE:    state_d = valid_i ? WORKING : IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         quot_q   <= '0;
         result_q <= '0;
         carry_q  <= '0;
         index_q  <= '0;
         last_q   <= '0;
      end else if (flush_i) begin
         result_q <= '0;
         carry_q  <= '0;
         index_q  <= '0;
      end else if (accept) begin
         quot_q   <= quot_ext;
         result_q <= '0;
         carry_q  <= remainder_i[WIDTH_CARRY-1:0];
         index_q  <= '0;
         last_q   <= last_acc;
      end else if (state_q == WORKING) begin
         result_q <= result_d;
         carry_q  <= carry_nxt;
         if (!finish) index_q <= index_q + 1'b1;
      end
   end

`ifdef CINT_MUL_OVERFLOW_EN
   logic ovf_q, ovf_d;

   assign ovf_d = ((result_d >> WIDTH_INPUT) != '0) || ((index_q == IDX_TOP) && (carry_nxt != '0));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 ovf_q <= 1'b0;
      else if (flush_i || accept)  ovf_q <= 1'b0;
      else if (finish)             ovf_q <= ovf_d;
   end

   assign overflow_o = ovf_q;
`else
   assign overflow_o = 1'b0;
`endif

   assign busy_o       = (state_q == WORKING);
   assign valid_o      = (state_q == DONE);
   assign valid_next_o = finish && !flush_i;
   assign value_o      = result_q[WIDTH_INPUT-1:0];

endmodule

// File: tb/tb_cint_multiplier.sv
// Directed bench for cint_multiplier (C=10, radix 4, 32-bit) with hand-computed results.
module tb_cint_multiplier;

   logic        clk_i = 1'b0;
   logic        rst_ni, flush_i, valid_i;
   logic [31:0] quotient_i, remainder_i, value_o;
   logic        busy_o, valid_o, valid_next_o, overflow_o;

   int n_cmp = 0;
   int n_err = 0;

`ifdef CINT_MUL_OVERFLOW_EN
   localparam logic OVF_FULL = 1'b1;
`else
   localparam logic OVF_FULL = 1'b0;
`endif

   cint_multiplier #(
      .VALUE_MULTIPLIER(10),
      .WIDTH_INPUT     (32),
      .WIDTH_RADIX     (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .quotient_i  (quotient_i),
      .remainder_i (remainder_i),
      .busy_o      (busy_o),
      .valid_o     (valid_o),
      .valid_next_o(valid_next_o),
      .value_o     (value_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for valid_o (bounded); lat counts cycles since the accept cycle.
   task automatic wait_valid(output int lat, output logic prev_next);
      lat = 1;
      prev_next = 1'b0;
      while (!valid_o && lat < 20) begin
         prev_next = valid_next_o;
         @(negedge clk_i);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] q, input logic [31:0] r,
                         input logic [31:0] exp_val, input int exp_lat, input logic exp_ovf);
      int   lat;
      logic prev_next;
      valid_i = 1'b1; quotient_i = q; remainder_i = r;
      @(negedge clk_i);
      valid_i = 1'b0;
      check({tag, ".busy"}, 64'(busy_o), 64'd1);
      wait_valid(lat, prev_next);
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".valid_next"}, 64'(prev_next), 64'd1);
      check({tag, ".value"}, 64'(value_o), 64'(exp_val));
      check({tag, ".overflow"}, 64'(overflow_o), 64'(exp_ovf));
      @(negedge clk_i);
      check({tag, ".pulse"}, 64'(valid_o), 64'd0);
      check({tag, ".idle"}, 64'(busy_o), 64'd0);
      check({tag, ".hold"}, 64'(value_o), 64'(exp_val));
   endtask

   initial begin
      int   lat;
      int   stray;
      logic prev_next;
      rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; quotient_i = '0; remainder_i = '0;
      repeat (2) @(negedge clk_i);
      check("rst.busy", 64'(busy_o), 64'd0);
      check("rst.valid", 64'(valid_o), 64'd0);
      check("rst.value", 64'(value_o), 64'd0);
      check("rst.ovf", 64'(overflow_o), 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      run_op("mul123", 32'd123, 32'd4, 32'h4D2, 3, 1'b0);
      run_op("zero_q", 32'd0, 32'd7, 32'd7, 2, 1'b0);
      run_op("all_ones", 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF6, 9, OVF_FULL);

      // Back-to-back: second operands presented during the DONE cycle.
      valid_i = 1'b1; quotient_i = 32'd123; remainder_i = 32'd4;
      @(negedge clk_i);
      valid_i = 1'b0;
      wait_valid(lat, prev_next);
      check("b2b.first_lat", 64'(lat), 64'd3);
      check("b2b.first_value", 64'(value_o), 64'h4D2);
      valid_i = 1'b1; quotient_i = 32'd45; remainder_i = 32'd6;
      @(negedge clk_i);
      valid_i = 1'b0;
      check("b2b.no_gap", 64'(busy_o), 64'd1);
      check("b2b.pulse", 64'(valid_o), 64'd0);
      wait_valid(lat, prev_next);
      check("b2b.second_lat", 64'(lat), 64'd3);
      check("b2b.second_value", 64'(value_o), 64'h1C8);
      @(negedge clk_i);

      // Flush mid-operation: no result for the aborted op.
      valid_i = 1'b1; quotient_i = 32'h1234_5678; remainder_i = 32'd3;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      flush_i = 1'b1;
      check("flush.valid_next", 64'(valid_next_o), 64'd0);
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush.busy", 64'(busy_o), 64'd0);
      check("flush.value", 64'(value_o), 64'd0);
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (valid_o) stray++;
         @(negedge clk_i);
      end
      check("flush.no_valid", 64'(stray), 64'd0);
      run_op("after_flush", 32'd5, 32'd0, 32'd50, 2, 1'b0);

      // Asynchronous reset mid-operation.
      valid_i = 1'b1; quotient_i = 32'hFFFF_FFFF; remainder_i = 32'd0;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("arst.busy", 64'(busy_o), 64'd0);
      check("arst.valid", 64'(valid_o), 64'd0);
      check("arst.valid_next", 64'(valid_next_o), 64'd0);
      check("arst.value", 64'(value_o), 64'd0);
      check("arst.ovf", 64'(overflow_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_op("after_rst", 32'd99, 32'd9, 32'h3E7, 3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
